// File: rtl/motor_pkg.sv
// -----------------------------------------------------------------------------
// motor_pkg
//   Shared definitions for the stepper-motor datapath.
//   - seq_state_e : move-sequencer state (IDLE / RUN / DONE)
//   - PH_W        : width of the phase index (8 half-step phases)
//   - PHASE_TABLE : coil pattern {B', A', B, A} for each phase index
//   - COIL_OFF    : all coils de-energised (power-up value only)
// -----------------------------------------------------------------------------
package motor_pkg;

  localparam int PH_W = 3;

  localparam logic [3:0] COIL_OFF = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Packed so that PHASE_TABLE[i] selects phase i. The leftmost entry is
  // index 7. Odd indices energise two coils (full-step positions), and even
  // indices energise one coil (the extra half-step positions).
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001,  // 7
    4'b1000,  // 6
    4'b1100,  // 5
    4'b0100,  // 4
    4'b0110,  // 3
    4'b0010,  // 2
    4'b0011,  // 1
    4'b0001   // 0
  };

endpackage

// File: rtl/coil_phase_lut.sv
// -----------------------------------------------------------------------------
// coil_phase_lut
//   Combinational phase-index to coil-pattern decoder. This block is shared
//   with the microstep and driver blocks.
//   Ports:
//     phase_idx [PH_W-1:0] in  : phase index 0..7
//     coil_pat  [3:0]      out : coil drive pattern {B', A', B, A}
// -----------------------------------------------------------------------------
module coil_phase_lut
  import motor_pkg::*;
(
  input  logic [PH_W-1:0] phase_idx,
  output logic [3:0]      coil_pat
);

  assign coil_pat = PHASE_TABLE[phase_idx];

endmodule

// File: rtl/motion_sequencer.sv
// -----------------------------------------------------------------------------
// motion_sequencer
//   Command-driven step sequencer. The block accepts a move through a
//   valid/ready handshake. It advances the phase index on each rising edge of
//   step_tick and drives the four coil outputs. A move can be aborted.
//   Ports:
//     clk, rst (async, active-low)
//     cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//     cmd_steps  : step count (ignored for continuous moves)
//     cmd_dir    : 1 = forward (index +), 0 = reverse (index -)
//     cmd_half   : 1 = half-step, 0 = full-step (two coils on)
//     cmd_cont   : 1 = run until abort
//     abort      : end the current move
//     step_tick  : step-rate strobe; each rising edge requests one step
//     coil       : coil drive {B', A', B, A}, registered
//     busy       : a move is in progress
//     done       : one-cycle pulse at the end of every move
//     steps_left : steps remaining in the current move
// -----------------------------------------------------------------------------
module motion_sequencer
  import motor_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic             cmd_half,
  input  logic             cmd_cont,
  input  logic             abort,
  input  logic             step_tick,
  output logic [3:0]       coil,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  seq_state_e       state_q, state_d;
  logic [PH_W-1:0]  index_q, index_d;
  logic [3:0]       coil_q, coil_d;
  logic [CNT_W-1:0] steps_left_q, steps_left_d;
  logic             dir_q, dir_d;
  logic             half_q, half_d;
  logic             cont_q, cont_d;
  logic             tick_q;

  logic             tick_edge;
  logic             accept;
  logic             phase_load;
  logic [PH_W-1:0]  step_amt;
  logic [3:0]       lut_pat;

  // A step_tick held high for several cycles counts as a single request.
  assign tick_edge = step_tick & ~tick_q;

  assign accept    = cmd_valid && (state_q == ST_IDLE);

  // A half step moves one phase. A full step moves two phases, so the index
  // stays on the odd (two-coil) positions.
  assign step_amt  = half_q ? PH_W'(1) : PH_W'(2);

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    steps_left_d = steps_left_q;
    dir_d        = dir_q;
    half_d       = half_q;
    cont_d       = cont_q;
    phase_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dir_d        = cmd_dir;
          half_d       = cmd_half;
          cont_d       = cmd_cont;
          steps_left_d = cmd_cont ? '0 : cmd_steps;
          // Full-step moves start from the nearest two-coil position. This
          // alignment is not counted as a step. OR-ing in bit 0 has no
          // effect when the index is already odd.
          index_d      = cmd_half ? index_q : (index_q | PH_W'(1));
          phase_load   = 1'b1;
          state_d      = (!cmd_cont && (cmd_steps == '0)) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        // An abort takes priority over a tick edge in the same cycle.
        // Position and count hold.
        if (abort) begin
          state_d = ST_DONE;
        end else if (tick_edge) begin
          // The 3-bit index wraps modulo 8 in both directions.
          index_d    = dir_q ? (index_q + step_amt) : (index_q - step_amt);
          phase_load = 1'b1;
          if (!cont_q) begin
            steps_left_d = steps_left_q - CNT_W'(1);
            if (steps_left_q == CNT_W'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  coil_phase_lut u_coil_phase_lut (
    .phase_idx (index_d),
    .coil_pat  (lut_pat)
  );

  // The coils are only reloaded when the phase changes. Otherwise they hold
  // the last pattern, which keeps holding torque in IDLE and DONE.
  assign coil_d = phase_load ? lut_pat : coil_q;

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // sample the pre-edge values, with no race between processes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      index_q      <= '0;
      coil_q       <= COIL_OFF;
      steps_left_q <= '0;
      dir_q        <= 1'b0;
      half_q       <= 1'b0;
      cont_q       <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      coil_q       <= coil_d;
      steps_left_q <= steps_left_d;
      dir_q        <= dir_d;
      half_q       <= half_d;
      cont_q       <= cont_d;
      tick_q       <= step_tick;
    end
  end

  assign coil       = coil_q;
  assign steps_left = steps_left_q;
  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_motion_sequencer.sv
// -----------------------------------------------------------------------------
// tb_motion_sequencer
//   Self-checking bench for motion_sequencer. A behavioural model follows the
//   move rules in terms of an integer rotor position, a remaining-step count
//   and a move phase. Each cycle, every output is compared with the model.
//   Directed scenarios come first, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_motion_sequencer;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_dir;
  logic             cmd_half;
  logic             cmd_cont;
  logic             abort;
  logic             step_tick;
  logic [3:0]       coil;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] steps_left;

  motion_sequencer #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_dir    (cmd_dir),
    .cmd_half   (cmd_half),
    .cmd_cont   (cmd_cont),
    .abort      (abort),
    .step_tick  (step_tick),
    .coil       (coil),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [3:0] ref_table [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0100, 4'b1100, 4'b1000, 4'b1001};

  localparam int M_IDLE = 0, M_MOVING = 1, M_ENDING = 2;

  int         m_mode;
  int         m_pos;
  int         m_left;
  logic [3:0] m_coil;
  bit         m_dir, m_half, m_cont, m_prev_tick;

  task automatic model_reset();
    m_mode      = M_IDLE;
    m_pos       = 0;
    m_left      = 0;
    m_coil      = 4'b0000;
    m_dir       = 1'b0;
    m_half      = 1'b0;
    m_cont      = 1'b0;
    m_prev_tick = 1'b0;
  endtask

  // Advance the model by one rising clock edge, using the current inputs.
  task automatic model_edge();
    bit rise;
    int delta;
    rise        = step_tick && !m_prev_tick;
    m_prev_tick = step_tick;
    if (m_mode == M_IDLE) begin
      if (cmd_valid) begin
        m_dir  = cmd_dir;
        m_half = cmd_half;
        m_cont = cmd_cont;
        if (!cmd_half && (m_pos % 2 == 0)) m_pos = m_pos + 1;
        m_coil = ref_table[m_pos];
        m_left = cmd_cont ? 0 : int'(cmd_steps);
        m_mode = (!cmd_cont && cmd_steps == 0) ? M_ENDING : M_MOVING;
      end
    end else if (m_mode == M_MOVING) begin
      if (abort) begin
        m_mode = M_ENDING;
      end else if (rise) begin
        delta  = (m_half ? 1 : 2) * (m_dir ? 1 : -1);
        m_pos  = ((m_pos + delta) % 8 + 8) % 8;
        m_coil = ref_table[m_pos];
        if (!m_cont) begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = M_ENDING;
        end
      end
    end else begin
      m_mode = M_IDLE;
    end
  endtask

  task automatic compare_all();
    check("coil",       32'(coil),       32'(m_coil));
    check("steps_left", 32'(steps_left), 32'(m_left));
    check("cmd_ready",  32'(cmd_ready),  32'(m_mode == M_IDLE));
    check("busy",       32'(busy),       32'(m_mode == M_MOVING));
    check("done",       32'(done),       32'(m_mode == M_ENDING));
    if (done === 1'b1) done_seen++;
  endtask

  // One clock cycle. The caller sets the inputs just after an edge. Outputs
  // are sampled 1 ns after the next edge.
  task automatic clk_step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Step pulse: high for one cycle, then low for one cycle.
  task automatic tick_pulse(input string tag, input logic [3:0] exp_coil);
    step_tick = 1'b1;
    clk_step();
    check(tag, 32'(coil), 32'(exp_coil));
    step_tick = 1'b0;
    clk_step();
  endtask

  task automatic issue(input int steps, input bit dir, input bit half, input bit cont);
    cmd_valid = 1'b1;
    cmd_steps = CNT_W'(steps);
    cmd_dir   = dir;
    cmd_half  = half;
    cmd_cont  = cont;
    clk_step();
    cmd_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) clk_step();
  endtask

  // Assert reset between clock edges. The outputs must drop at once, and no
  // done pulse may follow.
  task automatic async_reset_mid();
    #3;
    rst       = 1'b0;
    step_tick = 1'b0;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    #1;
    check("rst_coil",  32'(coil),       32'h0);
    check("rst_ready", 32'(cmd_ready),  32'h1);
    check("rst_busy",  32'(busy),       32'h0);
    check("rst_done",  32'(done),       32'h0);
    check("rst_left",  32'(steps_left), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_no_done", 32'(done), 32'h0);
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_steps = '0;
    cmd_dir   = 1'b0;
    cmd_half  = 1'b0;
    cmd_cont  = 1'b0;
    abort     = 1'b0;
    step_tick = 1'b0;
    model_reset();

    @(posedge clk);
    #1;
    check("reset_coil",  32'(coil),       32'h0);
    check("reset_ready", 32'(cmd_ready),  32'h1);
    check("reset_busy",  32'(busy),       32'h0);
    check("reset_done",  32'(done),       32'h0);
    check("reset_left",  32'(steps_left), 32'h0);
    rst = 1'b1;
    idle_cycles(2);

    // Full-step forward, 4 steps: the start at index 0 snaps to 1.
    done_seen = 0;
    issue(4, 1'b1, 1'b0, 1'b0);
    check("t1_accept_coil", 32'(coil), 32'h3);
    check("t1_accept_busy", 32'(busy), 32'h1);
    tick_pulse("t1_step1", 4'b0110);
    tick_pulse("t1_step2", 4'b1100);
    tick_pulse("t1_step3", 4'b1001);
    tick_pulse("t1_step4", 4'b0011);
    idle_cycles(3);
    check("t1_done_once", 32'(done_seen), 32'h1);
    check("t1_left_end",  32'(steps_left), 32'h0);
    check("t1_coil_hold", 32'(coil), 32'h3);

    // Half-step reverse, 3 steps from index 1, wrapping from 0 to 7.
    issue(3, 1'b0, 1'b1, 1'b0);
    check("t2_accept_coil", 32'(coil), 32'h3);
    tick_pulse("t2_step1", 4'b0001);
    tick_pulse("t2_step2", 4'b1001);
    tick_pulse("t2_step3", 4'b1000);
    idle_cycles(1);
    tick_pulse("t2_tick_idle", 4'b1000);

    // Zero-step command (half mode, so no snap): done follows at once.
    issue(0, 1'b1, 1'b1, 1'b0);
    check("t3_done",      32'(done), 32'h1);
    check("t3_coil_same", 32'(coil), 32'h8);
    clk_step();
    check("t3_ready", 32'(cmd_ready), 32'h1);

    // Continuous full-step forward: index 6 snaps to 7, then 10 steps reach
    // index 3. An abort then arrives with the 11th tick edge.
    done_seen = 0;
    issue(9, 1'b1, 1'b0, 1'b1);
    check("t4_accept_coil", 32'(coil), 32'h9);
    for (int i = 0; i < 10; i++) begin
      step_tick = 1'b1;
      clk_step();
      step_tick = 1'b0;
      clk_step();
    end
    check("t4_coil_10", 32'(coil), 32'h6);
    step_tick = 1'b1;
    abort     = 1'b1;
    clk_step();
    abort     = 1'b0;
    step_tick = 1'b0;
    check("t4_abort_coil", 32'(coil), 32'h6);
    check("t4_abort_done", 32'(done), 32'h1);
    check("t4_abort_left", 32'(steps_left), 32'h0);
    idle_cycles(2);
    check("t4_done_once", 32'(done_seen), 32'h1);

    // Long tick while cmd_valid is pulsed during RUN: exactly one step, and no
    // second accept. Then an async reset arrives mid-move.
    issue(5, 1'b1, 1'b1, 1'b0);
    step_tick = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cmd_valid = (i == 5 || i == 12);
      cmd_steps = CNT_W'(2);
      clk_step();
    end
    cmd_valid = 1'b0;
    check("t5_one_step_coil", 32'(coil), 32'h4);
    check("t5_one_step_left", 32'(steps_left), 32'h4);
    check("t5_still_busy",    32'(busy), 32'h1);
    step_tick = 1'b0;
    clk_step();
    done_seen = 0;
    async_reset_mid();
    idle_cycles(2);
    check("t5_no_done_after_rst", 32'(done_seen), 32'h0);

    // Randomized traffic checked each cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_steps = CNT_W'($urandom_range(0, 5));
      cmd_dir   = 1'($urandom_range(0, 1));
      cmd_half  = 1'($urandom_range(0, 1));
      cmd_cont  = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 2) == 0) step_tick = ~step_tick;
      clk_step();
      if ($urandom_range(0, 599) == 0) async_reset_mid();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
